// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed seven-segment display driver. Scans DIGITS hex
//               digits, each with its own decimal point, onto a shared
//               cathode bus. value/dp are captured into shadow registers on
//               load; the scan reads only the shadow copy.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous reset, active-high
//               value - 4*DIGITS hex nibbles, digit 0 in bits [3:0]
//               dp    - decimal point per digit
//               load  - capture value/dp into the shadow registers
//               en    - display enable (scan holds and outputs blank when 0)
//               an    - one-hot digit select (polarity per ACTIVE_LOW)
//               cat   - {dp, g..a} segment drive (polarity per ACTIVE_LOW)
// Options     : SEG_LEADING_ZERO_BLANK_EN - blank leading zero digits (k>0)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  en,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            cat
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;

    localparam logic [PW-1:0] c_PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(DIGITS - 1);
    localparam logic          c_AL         = (ACTIVE_LOW != 0);

    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [4*DIGITS-1:0]    val_q,   val_d;
    logic [DIGITS-1:0]      dp_q,    dp_d;
    logic [DIGITS-1:0]      an_q,    an_d;
    logic [7:0]             cat_q,   cat_d;

    logic                   w_tick;
    logic [3:0]             w_nib;
    logic                   w_dp_cur;
    logic                   w_blank;
    logic [DIGITS-1:0]      w_an_hi;
    logic [7:0]             w_cat_hi;

    // Hex to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign w_tick = (presc_q == c_PRESC_LAST) && en;

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
        end
        if (w_tick) begin
            idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow copy; the scan sees the new data from the edge after load.
    assign val_d = load ? value : val_q;
    assign dp_d  = load ? dp    : dp_q;

    assign w_nib    = val_q[{idx_q, 2'b00} +: 4];
    assign w_dp_cur = dp_q[idx_q];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // w_lead_zero[k] is set when digit k and every digit above it show a
    // zero nibble with no decimal point. Digit 0 is always displayed.
    logic [DIGITS-1:0] w_lead_zero;
    logic              w_run;

    always_comb begin
        w_lead_zero = '0;
        w_run       = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run          = w_run && (val_q[4*k +: 4] == 4'h0) && !dp_q[k];
            w_lead_zero[k] = w_run;
        end
    end

    assign w_blank = w_lead_zero[idx_q];
`else
    assign w_blank = 1'b0;
`endif

    // Build the active-high view first, then apply output polarity once.
    always_comb begin
        w_an_hi  = '0;
        w_cat_hi = '0;
        if (en && !w_blank) begin
            w_an_hi[idx_q] = 1'b1;
            w_cat_hi       = {w_dp_cur, hex7(w_nib)};
        end
    end

    assign an_d  = w_an_hi  ^ {DIGITS{c_AL}};
    assign cat_d = w_cat_hi ^ {8{c_AL}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dp_q    <= '0;
            an_q    <= {DIGITS{c_AL}};
            cat_q   <= {8{c_AL}};
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            cat_q   <= cat_d;
        end
    end

    assign an  = an_q;
    assign cat = cat_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Self-checking bench for seg_scan_display (DIGITS=4,
//               CLK_DIV=4, ACTIVE_LOW=1). A behavioural model tracks slot
//               position, digit index and shadow data with plain integer
//               arithmetic; directed sequences check the corner cases
//               against literal expected patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        en;
    logic [3:0]  an;
    logic [7:0]  cat;

    seg_scan_display #(
        .DIGITS     (DIGITS),
        .CLK_DIV    (CLK_DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .dp    (dp),
        .load  (load),
        .en    (en),
        .an    (an),
        .cat   (cat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_presc;
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [6:0]  c_seg [16];

    logic [15:0] cur_v;
    logic [3:0]  cur_d;

    typedef struct {
        logic [3:0] an;
        logic [7:0] cat;
        int         n;
    } slot_t;

    slot_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_blank(input int k);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (k > 0) && ((m_val >> (4 * k)) == 0) && ((m_dp >> k) == 0);
`else
        return (k < 0);
`endif
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cyc(input logic [15:0] v, input logic [3:0] d,
                       input logic ld, input logic e, input logic r);
        logic [3:0] ea;
        logic [7:0] ec;
        value = v; dp = d; load = ld; en = e; rst = r;
        cur_v = v; cur_d = d;
        @(posedge clk);
        ea = 4'hF;
        ec = 8'hFF;
        if (r) begin
            m_presc = 0; m_idx = 0; m_val = '0; m_dp = '0;
        end else begin
            if (e && !model_blank(m_idx)) begin
                ea = ~(4'b0001 << m_idx);
                ec = ~{m_dp[m_idx], c_seg[(m_val >> (4 * m_idx)) & 16'hF]};
            end
            if (ld) begin
                m_val = v; m_dp = d;
            end
            if (e) begin
                if (m_presc == CLK_DIV - 1) m_idx = (m_idx + 1) % DIGITS;
                m_presc = (m_presc + 1) % CLK_DIV;
            end
        end
        #1;
        chk("model_an", {28'h0, an}, {28'h0, ea});
        chk("model_cat", {24'h0, cat}, {24'h0, ec});
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(cur_v, cur_d, 1'b0, 1'b1, 1'b0);
    endtask

    // Run until the model reaches a slot position; bounded.
    task automatic wait_pos(input int idx, input int presc);
        int guard = 0;
        while (!((idx < 0 || m_idx == idx) && m_presc == presc) && guard < 100) begin
            cyc(cur_v, cur_d, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL wait_pos: timeout got idx=%0d presc=%0d", m_idx, m_presc);
        end
    endtask

    initial begin
        int cnt;
        int i0;
        logic [15:0] rv;
        logic [3:0]  rd;

        c_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        tbl[0] = '{an: 4'hE, cat: 8'h99, n: 3};
        tbl[1] = '{an: 4'hD, cat: 8'hB0, n: 4};
        tbl[2] = '{an: 4'hB, cat: 8'hA4, n: 4};
        tbl[3] = '{an: 4'h7, cat: 8'hF9, n: 4};
        tbl[4] = '{an: 4'hE, cat: 8'h99, n: 4};

        rst = 1'b1; value = '0; dp = '0; load = 1'b0; en = 1'b1;
        cur_v = '0; cur_d = '0;
        m_presc = 0; m_idx = 0; m_val = '0; m_dp = '0;

        cyc(16'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        cyc(16'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("reset_an", {28'h0, an}, 32'hF);
        chk("reset_cat", {24'h0, cat}, 32'hFF);

        // Run a little, then assert reset away from any edge.
        cyc(16'h1234, 4'h0, 1'b1, 1'b1, 1'b0);
        hold(5);
        rst = 1'b1;
        #2;
        chk("async_rst_an", {28'h0, an}, 32'hF);
        chk("async_rst_cat", {24'h0, cat}, 32'hFF);
        cyc(16'h1234, 4'h0, 1'b0, 1'b1, 1'b1);

        // Release with a load: first slot is digit 0 with the cleared shadow.
        cyc(16'h1234, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("release_an", {28'h0, an}, 32'hE);
        chk("release_cat", {24'h0, cat}, 32'hC0);

        // Scan timing table
        foreach (tbl[s]) begin
            for (int c = 0; c < tbl[s].n; c++) begin
                cyc(16'h1234, 4'h0, 1'b0, 1'b1, 1'b0);
                chk($sformatf("scan_an[%0d]", s), {28'h0, an}, {28'h0, tbl[s].an});
                chk($sformatf("scan_cat[%0d]", s), {24'h0, cat}, {24'h0, tbl[s].cat});
            end
        end

        // Mid-slot load during digit 0
        wait_pos(0, 1);
        cyc(16'h000F, 4'b0001, 1'b1, 1'b1, 1'b0);
        cyc(16'h000F, 4'b0001, 1'b0, 1'b1, 1'b0);
        chk("midload_cat", {24'h0, cat}, 32'h0E);
        chk("midload_an", {28'h0, an}, 32'hE);

        // Load on the tick edge
        wait_pos(-1, CLK_DIV - 1);
        i0 = m_idx;
        cyc(16'h8888, 4'hF, 1'b1, 1'b1, 1'b0);
        cyc(16'h8888, 4'hF, 1'b0, 1'b1, 1'b0);
        chk("loadtick_an", {28'h0, an}, {28'h0, ~(4'b0001 << ((i0 + 1) % DIGITS))});
        chk("loadtick_cat", {24'h0, cat}, 32'h00);

        // Enable pause during digit 2 with two clocks left in the slot
        wait_pos(2, 2);
        for (int i = 0; i < 10; i++) begin
            cyc(16'h8888, 4'hF, 1'b0, 1'b0, 1'b0);
            chk("en0_an", {28'h0, an}, 32'hF);
            chk("en0_cat", {24'h0, cat}, 32'hFF);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(16'h8888, 4'hF, 1'b0, 1'b1, 1'b0);
            if (an == 4'hB) cnt++;
            else break;
        end
        chk("resume_len", cnt, CLK_DIV - 2);
        chk("resume_next", {28'h0, an}, 32'h7);

        // Leading zeros: value 0050
        cyc(16'h0050, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2 * DIGITS * CLK_DIV; i++) begin
            cyc(16'h0050, 4'h0, 1'b0, 1'b1, 1'b0);
            if (an == 4'hD) chk("lz_d1", {24'h0, cat}, 32'h92);
            else if (an == 4'hE) chk("lz_d0", {24'h0, cat}, 32'hC0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            else chk("lz_blank", {20'h0, an, cat}, 32'hFFF);
`else
            else chk("lz_shown", {24'h0, cat}, 32'hC0);
`endif
        end

        // value 0 with dp on digit 3: nothing blanked, digit 3 shows '0.'
        cyc(16'h0000, 4'b1000, 1'b1, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < DIGITS * CLK_DIV; i++) begin
            cyc(16'h0000, 4'b1000, 1'b0, 1'b1, 1'b0);
            if (an == 4'h7) begin
                cnt++;
                chk("dp3_cat", {24'h0, cat}, 32'h40);
            end
        end
        chk("dp3_slot_len", cnt, CLK_DIV);

        // Randomised run against the model
        for (int i = 0; i < 600; i++) begin
            rv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
            rd = 4'($urandom);
            if ($urandom_range(0, 1) == 0) rd = 4'h0;
            cyc(rv, rd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment display driver.
- Scans DIGITS hex digits with per-digit decimal points onto a shared cathode bus.
- Sits between the processor's output/debug register and the board's an/cat pins.
- Successor to the fixed 4-digit driver: adds digit count, refresh rate and polarity parameters, a shadowed load, enable, and reset.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- CLK_DIV, 50000, clk cycles per digit slot (>=2).
- ACTIVE_LOW, 1, 1 = an/cat asserted low (common anode); 0 = asserted high.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- value  in  4*DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
- dp  in  DIGITS  decimal point per digit; dp[k] with digit k.
- load  in  1  strobe; latches value/dp into shadow registers at this edge.
- en  in  1  display enable.
- an  out  DIGITS  digit select, one-hot asserted during active slot.
- cat  out  8  cat[0..6] = segments a..g, cat[7] = dp.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, index=0, shadow value/dp=0.
  - an = all deasserted (all 1s when ACTIVE_LOW=1).
  - cat = all deasserted (8'hFF when ACTIVE_LOW=1).
  - Held while rst high; release is synchronous to the next clk edge.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (prescaler==CLK_DIV-1) && en.
  - Width is clog2(CLK_DIV).
- Scan index:
  - On tick, index advances 0,1,..,DIGITS-1, then wraps to 0.
  - Width is clog2(DIGITS), minimum 1.
- Shadow:
  - load=1 at an edge copies value/dp into the shadow at that edge.
  - The display reads only the shadow, so mid-slot loads change the current digit's cat one cycle later.
  - load and tick in the same cycle: both take effect; the new index displays the new shadow data.
- Outputs: registered, updated every clk from index and shadow (one clk latency after an index or shadow change).
  - an: bit[index] asserted, all other bits deasserted.
  - cat[6:0]: hex decode of the shadow nibble at index.
  - cat[7]: shadow dp[index].
- Hex decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - With ACTIVE_LOW=1, the whole {dp,seg} byte is inverted: '0' no dp -> C0, '1' -> F9, '8' with dp -> 00.
- en:
  - en=0: prescaler and index hold; an/cat deasserted on the next clk.
  - en 0->1: resumes at the held index and prescaler value.
  - load still works while en=0.
- Reset mid-scan: immediate blank; after release, scanning restarts at digit 0 with a full CLK_DIV slot.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - A zero digit k>0 is blanked if every shadow nibble at k..DIGITS-1 is zero and dp[k..DIGITS-1] are all zero.
  - Blanked slot: an deasserted, cat deasserted; slot timing unchanged.
  - Digit 0 is never blanked.
- When undefined: all digits always shown, including leading zeros.

Test Plan:
- Reset: rst=1 mid-run, sampled before any clk edge -> an=4'hF, cat=8'hFF; after release, first slot digit 0.
- Scan timing (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1):
  - Stimulus: load value=16'h1234, dp=4'b0000.
  - an sequence: E,D,B,7, each 4 clks, wraps to E.
  - cat sequence: 99('4'), B0('3'), A4('2'), F9('1').
- Load mid-slot: during digit 0 slot, load value=16'h000F, dp=4'b0001 -> cat changes to 0E one clk later; an slot length unaffected.
- Enable:
  - Stimulus: en=0 for 10 clks during digit 2 slot.
  - Response: an=F, cat=FF after one clk.
  - en=1 -> digit 2 resumes with the remaining prescaler count, no skipped digit.
- Load with tick: load asserted on the tick edge -> next digit shows new data on its first displayed cycle.
- With SEG_LEADING_ZERO_BLANK_EN:
  - value=16'h0050 -> digits 3,2 blanked (an bits 3,2 stay 1); digit 1 shows 92('5'); digit 0 shows C0.
  - value=0 -> only digit 0 lit with C0.
  - dp=4'b1000 with value=0 -> no digit blanked.
